mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline latch, on the reading side of that interface.
//  Takes the latched ALU result, address, store data, flags, destination indices and
//  memRd/memWt. Runs a req/ack handshake to data memory and stalls the pipe during waits.
//  Loads the MEM/WB register that feeds register-file write-back.
// PARAMETERS
//  DATA_W     32  ALU result / write-back data width
//  ADDR_W     32  data-memory address width
//  MEM_W      8   memory data width; matches the 8-bit regrd2 store operand
//  IDX_W      3   register index width (rd1, rd2)
//  TIMEOUT    16  cycles in WAIT before abort; used only with MEM_WB_TIMEOUT_EN
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       EX/MEM latch holds a live instruction
//  alu_in     in   DATA_W  exe_mem_aluOutOutput
//  addr_in    in   ADDR_W  ex_mem_memAddr_out
//  st_data    in   MEM_W   exe_mem_regrd2_out
//  flags_in   in   4       {N,Z,C,V} from EX/MEM
//  rd1_in     in   IDX_W   ex_mem_rd1_out;  we1_in  in 1  write enable for rd1
//  rd2_in     in   IDX_W   ex_mem_rd2_out;  we2_in  in 1  write enable for rd2
//  mem_rd     in   1       load;  mem_wt  in 1  store
//  mem_req    out  1       memory request, held until ack
//  mem_we     out  1       1=write, 0=read; valid while mem_req
//  mem_addr   out  ADDR_W  captured address;  mem_wdata  out MEM_W  captured store data
//  mem_rdata  in   MEM_W   read data, sampled on mem_ack
//  mem_ack    in   1       one-cycle completion pulse
//  stall      out  1       hold IF..EX/MEM; combinational
//  wb_valid   out  1       MEM/WB register holds a live instruction
//  wb_data    out  DATA_W  write-back value for rd1
//  wb_rd1 / wb_rd2  out  IDX_W;  wb_we1 / wb_we2  out 1  (gated by wb_valid)
//  wb_flags   out  4       NZCV carried to WB
//  mem_err    out  1       sticky timeout flag (MEM_WB_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - FSM states: IDLE, WAIT. Reset: IDLE; all outputs 0; mem_req=0; mem_err=0.
//  - Non-memory instruction: in_valid & !mem_rd & !mem_wt in IDLE.
//    Next edge loads MEM/WB: wb_data=alu_in, flags, indices, enables; wb_valid=1.
//    Latency 1 cycle; stall stays 0.
//  - Memory instruction in IDLE: stall=1 combinationally.
//    Next edge: capture addr/st_data/op into mem_*; mem_req=1; ->WAIT; wb_valid=0 (bubble).
//  - mem_rd & mem_wt both set: treated as store, mem_we=1; the load is dropped.
//  - WAIT: stall=1; mem_req, mem_addr, mem_wdata, mem_we held constant.
//    EX/MEM inputs ignored (upstream is frozen).
//  - mem_ack in WAIT: next edge: mem_req=0, ->IDLE, wb_valid=1.
//    Load: wb_data={DATA_W-MEM_W zeros, mem_rdata}. Store: wb_data=captured alu value.
//    stall=0 during the cycle after the ack.
//  - mem_ack sampled in IDLE is ignored. Earliest ack is the first WAIT cycle.
//    Minimum memory-op latency is 2 cycles.
//  - !in_valid in IDLE: wb_valid=0 next edge; other wb_* hold their value.
//  - reset in any state, including mid-WAIT: next edge ->IDLE, mem_req=0, wb_valid=0.
//    The pending access is abandoned.
// CONFIGURATION
//  MEM_WB_TIMEOUT_EN defined: counter cleared on WAIT entry, increments per WAIT cycle.
//    At TIMEOUT with no ack: mem_req=0, ->IDLE, wb_valid=1 with wb_we1=wb_we2=0.
//    mem_err set, sticky until reset. Counter width $clog2(TIMEOUT+1).
//  Undefined: WAIT holds indefinitely; no counter; mem_err tied 0.
// TESTING
//  ALU op alu_in=0x1234, rd1=3, we1=1 -> next cycle wb_valid=1, wb_data=0x1234, stall never high.
//  Load addr=0x40, ack on 3rd WAIT cycle, rdata=0xA5 -> stall high 4 cycles; wb_data=0x000000A5.
//  Store addr=0x10, st_data=0x5C, ack first WAIT cycle -> mem_we=1, mem_wdata=0x5C; wb_valid 2 cycles after issue.
//  mem_rd=mem_wt=1 -> mem_we=1; ack pulse while IDLE produces no wb_valid.
//  reset pulsed in WAIT -> mem_req=0, stall=0, wb_valid=0 next cycle; a later ack is ignored.
//  With MEM_WB_TIMEOUT_EN, TIMEOUT=16, no ack -> abort after 16 WAIT cycles; mem_err=1; wb_we1=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM stage: consumes the EX/MEM latch, runs a req/ack data-memory handshake and loads MEM/WB.
// Optional feature macro MEM_WB_TIMEOUT_EN: abort a stalled access after TIMEOUT WAIT cycles.
module mem_wb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_W   = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [MEM_W-1:0]  st_data,
  input  logic [3:0]        flags_in,
  input  logic [IDX_W-1:0]  rd1_in,
  input  logic              we1_in,
  input  logic [IDX_W-1:0]  rd2_in,
  input  logic              we2_in,
  input  logic              mem_rd,
  input  logic              mem_wt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [IDX_W-1:0]  wb_rd1,
  output logic [IDX_W-1:0]  wb_rd2,
  output logic              wb_we1,
  output logic              wb_we2,
  output logic [3:0]        wb_flags,
  output logic              mem_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e state_q, state_d;

  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [IDX_W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d;
  logic              we1_q, we1_d, we2_q, we2_d, load_q, load_d;
  logic [3:0]        flags_q, flags_d;
  logic              wb_valid_q, wb_valid_d, wb_we1_q, wb_we1_d, wb_we2_q, wb_we2_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [IDX_W-1:0]  wb_rd1_q, wb_rd1_d, wb_rd2_q, wb_rd2_d;
  logic [3:0]        wb_flags_q, wb_flags_d;
  logic              is_mem_c, tmo_c;

  assign is_mem_c = in_valid && (mem_rd || mem_wt);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mem_wb_stage: TIMEOUT must be at least 1");
  end

`ifdef MEM_WB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign tmo_c = (state_q == S_WAIT) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_d = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : '0;
  assign err_d = err_q || tmo_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`else
  assign tmo_c   = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (is_mem_c) state_d = S_WAIT;
      S_WAIT:  if (mem_ack || tmo_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; WB enables drop whenever no instruction retires.
  always_comb begin
    stall       = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    alu_d       = alu_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    we1_d       = we1_q;
    we2_d       = we2_q;
    load_d      = load_q;
    flags_d     = flags_q;
    wb_valid_d  = 1'b0;
    wb_we1_d    = 1'b0;
    wb_we2_d    = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd1_d    = wb_rd1_q;
    wb_rd2_d    = wb_rd2_q;
    wb_flags_d  = wb_flags_q;
    case (state_q)
      S_IDLE: begin
        if (is_mem_c) begin
          stall       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_wt;
          mem_addr_d  = addr_in;
          mem_wdata_d = st_data;
          alu_d       = alu_in;
          rd1_d       = rd1_in;
          rd2_d       = rd2_in;
          we1_d       = we1_in;
          we2_d       = we2_in;
          flags_d     = flags_in;
          load_d      = !mem_wt;
        end else if (in_valid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = alu_in;
          wb_rd1_d   = rd1_in;
          wb_rd2_d   = rd2_in;
          wb_we1_d   = we1_in;
          wb_we2_d   = we2_in;
          wb_flags_d = flags_in;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_ack || tmo_c) begin
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = (load_q && mem_ack) ? DATA_W'(mem_rdata) : alu_q;
          wb_rd1_d   = rd1_q;
          wb_rd2_d   = rd2_q;
          wb_we1_d   = we1_q && mem_ack;
          wb_we2_d   = we2_q && mem_ack;
          wb_flags_d = flags_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      alu_q       <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      we1_q       <= 1'b0;
      we2_q       <= 1'b0;
      load_q      <= 1'b0;
      flags_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_we1_q    <= 1'b0;
      wb_we2_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_rd1_q    <= '0;
      wb_rd2_q    <= '0;
      wb_flags_q  <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      alu_q       <= alu_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      we1_q       <= we1_d;
      we2_q       <= we2_d;
      load_q      <= load_d;
      flags_q     <= flags_d;
      wb_valid_q  <= wb_valid_d;
      wb_we1_q    <= wb_we1_d;
      wb_we2_q    <= wb_we2_d;
      wb_data_q   <= wb_data_d;
      wb_rd1_q    <= wb_rd1_d;
      wb_rd2_q    <= wb_rd2_d;
      wb_flags_q  <= wb_flags_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rd1    = wb_rd1_q;
  assign wb_rd2    = wb_rd2_q;
  assign wb_we1    = wb_we1_q;
  assign wb_we2    = wb_we2_q;
  assign wb_flags  = wb_flags_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed scenarios plus randomized transactions checked
// against a transaction-level expectation of what each instruction delivers to write-back.
module tb_mem_wb_stage;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned MEM_W   = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TIMEOUT = 16;

  logic              clk, reset, in_valid, we1_in, we2_in, mem_rd, mem_wt, mem_ack;
  logic [DATA_W-1:0] alu_in;
  logic [ADDR_W-1:0] addr_in;
  logic [MEM_W-1:0]  st_data, mem_rdata;
  logic [3:0]        flags_in;
  logic [IDX_W-1:0]  rd1_in, rd2_in;
  logic              mem_req, mem_we, stall, wb_valid, wb_we1, wb_we2, mem_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [DATA_W-1:0] wb_data;
  logic [IDX_W-1:0]  wb_rd1, wb_rd2;
  logic [3:0]        wb_flags;

  int n_cmp = 0;
  int n_err = 0;

  // Last values delivered to write-back (they persist across bubbles).
  logic [DATA_W-1:0] exp_data;
  logic [IDX_W-1:0]  exp_rd1, exp_rd2;
  logic [3:0]        exp_flags;

  mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_W(MEM_W), .IDX_W(IDX_W),
                 .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_in(alu_in), .addr_in(addr_in),
    .st_data(st_data), .flags_in(flags_in), .rd1_in(rd1_in), .we1_in(we1_in),
    .rd2_in(rd2_in), .we2_in(we2_in), .mem_rd(mem_rd), .mem_wt(mem_wt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .wb_rd1(wb_rd1), .wb_rd2(wb_rd2), .wb_we1(wb_we1),
    .wb_we2(wb_we2), .wb_flags(wb_flags), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; mem_rd = 1'b0; mem_wt = 1'b0; mem_ack = 1'b0;
    we1_in = 1'b0; we2_in = 1'b0; alu_in = '0; addr_in = '0; st_data = '0;
    flags_in = '0; rd1_in = '0; rd2_in = '0; mem_rdata = '0;
  endtask

  task automatic scramble_upstream();
    in_valid = 1'($urandom_range(0, 1)); mem_rd = 1'($urandom_range(0, 1));
    mem_wt = 1'($urandom_range(0, 1));   we1_in = 1'($urandom_range(0, 1));
    we2_in = 1'($urandom_range(0, 1));   alu_in = $urandom; addr_in = $urandom;
    st_data = 8'($urandom);              flags_in = 4'($urandom);
    rd1_in = 3'($urandom);               rd2_in = 3'($urandom);
  endtask

  task automatic check_wb(input string tag, input logic v, input logic e1, input logic e2);
    chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(v));
    chk({tag, ".wb_data"},  wb_data, exp_data);
    chk({tag, ".wb_rd1"},   32'(wb_rd1), 32'(exp_rd1));
    chk({tag, ".wb_rd2"},   32'(wb_rd2), 32'(exp_rd2));
    chk({tag, ".wb_we1"},   32'(wb_we1), 32'(e1));
    chk({tag, ".wb_we2"},   32'(wb_we2), 32'(e2));
    chk({tag, ".wb_flags"}, 32'(wb_flags), 32'(exp_flags));
  endtask

  // One randomized instruction: bubble, ALU op, load, store, or load+store (treated as store).
  task automatic rand_txn();
    int kind, dly;
    logic [DATA_W-1:0] a;
    logic [ADDR_W-1:0] ad;
    logic [MEM_W-1:0]  sd, rv;
    logic [3:0]        fl;
    logic [IDX_W-1:0]  r1, r2;
    logic              w1, w2, is_st;
    kind = $urandom_range(0, 4);
    a = $urandom; ad = $urandom; sd = 8'($urandom); rv = 8'($urandom); fl = 4'($urandom);
    r1 = 3'($urandom); r2 = 3'($urandom);
    w1 = 1'($urandom_range(0, 1)); w2 = 1'($urandom_range(0, 1));
    alu_in = a; addr_in = ad; st_data = sd; flags_in = fl;
    rd1_in = r1; rd2_in = r2; we1_in = w1; we2_in = w2;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = 8'($urandom);
    if (kind == 0) begin
      in_valid = 1'b0; mem_rd = 1'($urandom_range(0, 1)); mem_wt = 1'($urandom_range(0, 1));
      #1 chk("rnd_bubble.stall", 32'(stall), 32'd0);
      step();
      check_wb("rnd_bubble", 1'b0, 1'b0, 1'b0);
      chk("rnd_bubble.mem_req", 32'(mem_req), 32'd0);
    end else if (kind == 1) begin
      in_valid = 1'b1; mem_rd = 1'b0; mem_wt = 1'b0;
      #1 chk("rnd_alu.stall", 32'(stall), 32'd0);
      step();
      exp_data = a; exp_rd1 = r1; exp_rd2 = r2; exp_flags = fl;
      check_wb("rnd_alu", 1'b1, w1, w2);
    end else begin
      in_valid = 1'b1; mem_rd = (kind != 3); mem_wt = (kind != 2);
      is_st = (kind != 2);
      #1 chk("rnd_issue.stall", 32'(stall), 32'd1);
      step();
      dly = $urandom_range(1, 4);
      for (int k = 1; k <= dly; k++) begin
        chk("rnd_wait.mem_req",   32'(mem_req), 32'd1);
        chk("rnd_wait.mem_we",    32'(mem_we), 32'(is_st));
        chk("rnd_wait.mem_addr",  mem_addr, ad);
        chk("rnd_wait.mem_wdata", 32'(mem_wdata), 32'(sd));
        chk("rnd_wait.wb_valid",  32'(wb_valid), 32'd0);
        scramble_upstream();
        mem_ack = (k == dly);
        mem_rdata = (k == dly) ? rv : 8'($urandom);
        #1 chk("rnd_wait.stall", 32'(stall), 32'd1);
        step();
      end
      idle_inputs();
      exp_data = is_st ? a : 32'(rv);
      exp_rd1 = r1; exp_rd2 = r2; exp_flags = fl;
      check_wb("rnd_done", 1'b1, w1, w2);
      chk("rnd_done.mem_req", 32'(mem_req), 32'd0);
      #1 chk("rnd_done.stall", 32'(stall), 32'd0);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    exp_data = '0; exp_rd1 = '0; exp_rd2 = '0; exp_flags = '0;
    step(); step();
    check_wb("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_we",  32'(mem_we), 32'd0);
    chk("reset.stall",   32'(stall), 32'd0);
    chk("reset.mem_err", 32'(mem_err), 32'd0);
    reset = 1'b0;
    step();

    // ALU op: one-cycle latency, never stalls
    in_valid = 1'b1; alu_in = 32'h1234; rd1_in = 3'd3; we1_in = 1'b1;
    rd2_in = 3'd5; we2_in = 1'b0; flags_in = 4'hA;
    #1 chk("alu.stall", 32'(stall), 32'd0);
    step();
    idle_inputs();
    exp_data = 32'h1234; exp_rd1 = 3'd3; exp_rd2 = 3'd5; exp_flags = 4'hA;
    check_wb("alu", 1'b1, 1'b1, 1'b0);
    chk("alu.stall_after", 32'(stall), 32'd0);
    step();
    check_wb("alu_bubble", 1'b0, 1'b0, 1'b0);

    // Load at 0x40, ack on the third WAIT cycle: stall high for four cycles
    in_valid = 1'b1; mem_rd = 1'b1; addr_in = 32'h40; alu_in = 32'h7777;
    rd1_in = 3'd2; we1_in = 1'b1; flags_in = 4'h5;
    for (int c = 0; c < 4; c++) begin
      #1 chk("load.stall", 32'(stall), 32'd1);
      if (c == 1) begin
        chk("load.mem_req",  32'(mem_req), 32'd1);
        chk("load.mem_we",   32'(mem_we), 32'd0);
        chk("load.mem_addr", mem_addr, 32'h40);
        chk("load.bubble",   32'(wb_valid), 32'd0);
      end
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 8'hA5; end
      step();
      if (c == 0) begin in_valid = 1'b0; mem_rd = 1'b0; end
    end
    idle_inputs();
    exp_data = 32'h0000_00A5; exp_rd1 = 3'd2; exp_rd2 = 3'd0; exp_flags = 4'h5;
    check_wb("load", 1'b1, 1'b1, 1'b0);
    #1 chk("load.stall_after", 32'(stall), 32'd0);

    // Store at 0x10, ack on first WAIT cycle: wb_valid two cycles after issue
    in_valid = 1'b1; mem_wt = 1'b1; addr_in = 32'h10; st_data = 8'h5C; alu_in = 32'hDEAD;
    step();
    idle_inputs();
    chk("store.mem_we",    32'(mem_we), 32'd1);
    chk("store.mem_wdata", 32'(mem_wdata), 32'h5C);
    chk("store.mem_addr",  mem_addr, 32'h10);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    exp_data = 32'hDEAD; exp_rd1 = '0; exp_rd2 = '0; exp_flags = '0;
    check_wb("store", 1'b1, 1'b0, 1'b0);

    // Load and store together behave as a store; idle ack is ignored
    in_valid = 1'b1; mem_rd = 1'b1; mem_wt = 1'b1; alu_in = 32'hBEEF;
    step();
    idle_inputs();
    chk("both.mem_we", 32'(mem_we), 32'd1);
    mem_ack = 1'b1; mem_rdata = 8'h11;
    step();
    exp_data = 32'hBEEF;
    check_wb("both", 1'b1, 1'b0, 1'b0);
    step();
    mem_ack = 1'b0;
    check_wb("idle_ack", 1'b0, 1'b0, 1'b0);
    chk("idle_ack.mem_req", 32'(mem_req), 32'd0);
    chk("idle_ack.stall",   32'(stall), 32'd0);

    // Reset mid-WAIT abandons the access; a later ack has no effect
    in_valid = 1'b1; mem_rd = 1'b1; addr_in = 32'h80;
    step();
    idle_inputs();
    chk("rst_wait.pre_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_data = '0; exp_rd1 = '0; exp_rd2 = '0; exp_flags = '0;
    chk("rst_wait.mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait.stall",   32'(stall), 32'd0);
    check_wb("rst_wait", 1'b0, 1'b0, 1'b0);
    mem_ack = 1'b1; mem_rdata = 8'h99;
    step();
    mem_ack = 1'b0;
    check_wb("rst_late_ack", 1'b0, 1'b0, 1'b0);
    chk("rst_late_ack.mem_req", 32'(mem_req), 32'd0);

    for (int t = 0; t < 150; t++) rand_txn();

`ifdef MEM_WB_TIMEOUT_EN
    // No ack: abort after TIMEOUT WAIT cycles with write enables suppressed
    in_valid = 1'b1; mem_rd = 1'b1; we1_in = 1'b1; rd1_in = 3'd6; alu_in = 32'h55;
    step();
    idle_inputs();
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      chk("tmo.mem_req", 32'(mem_req), 32'd1);
      chk("tmo.stall",   32'(stall), 32'd1);
      step();
    end
    chk("tmo.abort_req", 32'(mem_req), 32'd0);
    chk("tmo.wb_valid",  32'(wb_valid), 32'd1);
    chk("tmo.wb_we1",    32'(wb_we1), 32'd0);
    chk("tmo.mem_err",   32'(mem_err), 32'd1);
    step();
    chk("tmo.sticky", 32'(mem_err), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("tmo.err_cleared", 32'(mem_err), 32'd0);
`else
    chk("no_tmo.mem_err", 32'(mem_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
